// File: rtl/alu_cond_pipe.sv
// alu_cond_pipe
// Two-stage pipelined ALU (ADD/SUB/AND/OR). It keeps an architectural NZCV
// flag register and executes each op conditionally, in the ARM style.
//
// Stage 1 registers the ALU result and the candidate NZCV for the op.
// Stage 2 tests the op's condition against the architectural flags. If the
// condition passes, it writes the result and (optionally) the new flags.
// Flags commit on the same edge that loads the next op into stage 2, so
// back-to-back ops see their predecessor's flags with no bubble and no
// forwarding path.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   in_valid / in_ready     issue-side handshake
//   a, b [WIDTH]            operands
//   alu_ctrl [2]            00 ADD, 01 SUB (a-b), 10 AND, 11 OR
//   set_flags               commit NZCV if the op executes
//   cond [4]                execution condition (EQ..LE, E/F = always)
//   out_valid / out_ready   writeback-side handshake
//   result [WIDTH]          last executed result (held when an op is skipped)
//   executed                1 = condition passed, 0 = skipped
//   flags [4]               architectural {N,Z,C,V}
//   skip_count [CNT_WIDTH]  saturating count of skipped ops; present only
//                           when ALU_COND_SKIP_CNT_EN is defined
module alu_cond_pipe #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_ctrl,
  input  logic             set_flags,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             executed,
  output logic [3:0]       flags
`ifdef ALU_COND_SKIP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] skip_count
`endif
);

  if (WIDTH < 2 || CNT_WIDTH < 1) begin : g_param_chk
    $error("alu_cond_pipe: WIDTH must be >= 2 and CNT_WIDTH >= 1");
  end

  // Condition check against {N,Z,C,V}; encodings 14 and 15 mean always.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, ok;
    {n, z, cy, v} = f;
    ok = 1'b1;
    case (c)
      4'h0: ok = z;
      4'h1: ok = !z;
      4'h2: ok = cy;
      4'h3: ok = !cy;
      4'h4: ok = n;
      4'h5: ok = !n;
      4'h6: ok = v;
      4'h7: ok = !v;
      4'h8: ok = cy & !z;
      4'h9: ok = !cy | z;
      4'hA: ok = (n == v);
      4'hB: ok = (n != v);
      4'hC: ok = !z & (n == v);
      4'hD: ok = z | (n != v);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

`ifdef ALU_COND_SKIP_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction
`endif

  // Handshake control
  logic vld_p1_d, vld_p1_q;
  logic out_valid_d, out_valid_q;
  logic s2_free, s1_adv;

  assign s2_free  = !out_valid_q | out_ready;
  assign s1_adv   = vld_p1_q & s2_free;
  assign in_ready = !vld_p1_q | s1_adv;

  // ---- stage 0 -> stage 1: ALU and candidate flags ----
  logic is_sub;
  logic [WIDTH-1:0] b_op, alu_res;
  logic [WIDTH:0]   sum_ext;
  logic             c_new, v_new;

  always_comb begin
    is_sub  = (alu_ctrl == 2'b01);
    // SUB is a + ~b + 1, so C comes out as "no borrow".
    b_op    = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    alu_res = sum_ext[WIDTH-1:0];
    c_new   = 1'b0;
    v_new   = 1'b0;
    case (alu_ctrl)
      2'b00, 2'b01: begin
        alu_res = sum_ext[WIDTH-1:0];
        c_new   = sum_ext[WIDTH];
        v_new   = (a[WIDTH-1] == b_op[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   alu_res = a & b;
      default: alu_res = a | b;
    endcase
  end

  logic [WIDTH-1:0] res_p1_d, res_p1_q;
  logic [3:0]       nzcv_p1_d, nzcv_p1_q;
  logic [3:0]       cond_p1_d, cond_p1_q;
  logic             setf_p1_d, setf_p1_q;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    res_p1_d  = res_p1_q;
    nzcv_p1_d = nzcv_p1_q;
    cond_p1_d = cond_p1_q;
    setf_p1_d = setf_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        res_p1_d  = alu_res;
        nzcv_p1_d = {alu_res[WIDTH-1], (alu_res == '0), c_new, v_new};
        cond_p1_d = cond;
        setf_p1_d = set_flags;
      end
    end
  end

  // ---- stage 1 -> stage 2: predicate, commit flags, present result ----
  logic [WIDTH-1:0] result_d, result_q;
  logic             executed_d, executed_q;
  logic [3:0]       flags_d, flags_q;
  logic             pass_p1;
`ifdef ALU_COND_SKIP_CNT_EN
  logic [CNT_WIDTH-1:0] skip_cnt_d, skip_cnt_q;
`endif

  always_comb begin
    pass_p1     = cond_pass(cond_p1_q, flags_q);
    out_valid_d = out_valid_q;
    result_d    = result_q;
    executed_d  = executed_q;
    flags_d     = flags_q;
`ifdef ALU_COND_SKIP_CNT_EN
    skip_cnt_d  = skip_cnt_q;
`endif
    // A held op is not evaluated until it actually moves into stage 2.
    if (s2_free) begin
      out_valid_d = vld_p1_q;
      if (vld_p1_q) begin
        executed_d = pass_p1;
        if (pass_p1) begin
          result_d = res_p1_q;
          if (setf_p1_q) flags_d = nzcv_p1_q;
        end
`ifdef ALU_COND_SKIP_CNT_EN
        else begin
          skip_cnt_d = sat_inc(skip_cnt_q);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      executed_q  <= 1'b0;
      flags_q     <= 4'b0000;
`ifdef ALU_COND_SKIP_CNT_EN
      skip_cnt_q  <= '0;
`endif
    end else begin
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      executed_q  <= executed_d;
      flags_q     <= flags_d;
`ifdef ALU_COND_SKIP_CNT_EN
      skip_cnt_q  <= skip_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    res_p1_q  <= res_p1_d;
    nzcv_p1_q <= nzcv_p1_d;
    cond_p1_q <= cond_p1_d;
    setf_p1_q <= setf_p1_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign executed  = executed_q;
  assign flags     = flags_q;
`ifdef ALU_COND_SKIP_CNT_EN
  assign skip_count = skip_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cond_pipe.sv
// Testbench for alu_cond_pipe (WIDTH=32, CNT_WIDTH=2).
// A reference model computes each op's outcome when the op is accepted and
// pushes it to a scoreboard queue. The queue is popped and compared whenever
// the DUT hands a result downstream. Directed phases also check their outputs
// against hand-derived constants.
module tb_alu_cond_pipe;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3;
  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_HS = 4'h2, C_LO = 4'h3,
                         C_GE = 4'hA, C_AL = 4'hE;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [1:0] alu_ctrl;
  logic set_flags, executed;
  logic [3:0] cond, flags;
`ifdef ALU_COND_SKIP_CNT_EN
  logic [CW-1:0] skip_count;
`endif

  always #5 clk = ~clk;

  alu_cond_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .set_flags(set_flags), .cond(cond),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .executed(executed), .flags(flags)
`ifdef ALU_COND_SKIP_CNT_EN
    , .skip_count(skip_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         exe;
    logic [3:0]   fl;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_res;
  logic [3:0]   m_fl;
  int stall_left = 0;
  bit stall_arm = 0, rand_ready = 0, saw_block = 0;
  bit acc_dummy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_push(input logic [W-1:0] pa, input logic [W-1:0] pb,
                            input logic [1:0] pc, input logic ps, input logic [3:0] pcond);
    logic [W:0] wide;
    logic [W-1:0] r;
    logic cy, v, exe;
    out_t e;
    cy = 1'b0; v = 1'b0; wide = '0;
    case (pc)
      OP_ADD: begin
        wide = {1'b0, pa} + {1'b0, pb};
        r  = wide[W-1:0];
        cy = wide[W];
        v  = (pa[W-1] == pb[W-1]) && (r[W-1] != pa[W-1]);
      end
      OP_SUB: begin
        r  = pa - pb;
        cy = (pa >= pb);
        v  = (pa[W-1] != pb[W-1]) && (r[W-1] != pa[W-1]);
      end
      OP_AND:  r = pa & pb;
      default: r = pa | pb;
    endcase
    exe = m_cond(pcond, m_fl);
    if (exe) begin
      m_res = r;
      if (ps) m_fl = {r[W-1], (r == 0), cy, v};
    end
    e.res = m_res; e.exe = exe; e.fl = m_fl;
    exp_q.push_back(e);
  endtask

  // One clock: choose out_ready, sample handshakes at the falling edge,
  // then return just after the next rising edge.
  task automatic tick(output bit acc);
    out_t got, e;
    if (stall_arm && out_valid) begin stall_left = 3; stall_arm = 0; end
    if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (in_valid && !in_ready) saw_block = 1;
    if (acc) model_push(a, b, alu_ctrl, set_flags, cond);
    if (out_valid && out_ready) begin
      got.res = result; got.exe = executed; got.fl = flags;
      obs_q.push_back(got);
      check("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", 64'(got.res), 64'(e.res));
        check("sb_executed", 64'(got.exe), 64'(e.exe));
        check("sb_flags", 64'(got.fl), 64'(e.fl));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] ic,
                       input logic is, input logic [3:0] icond);
    bit acc;
    int n;
    n = 0; acc = 0;
    a = ia; b = ib; alu_ctrl = ic; set_flags = is; cond = icond; in_valid = 1'b1;
    while (!acc && n < 50) begin tick(acc); n++; end
    check("accept_in_time", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin tick(acc); n++; end
    check("drain_in_time", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_obs(input int idx, input string tag, input logic [W-1:0] r,
                           input logic e, input logic [3:0] f);
    out_t want;
    want.res = r; want.exe = e; want.fl = f;
    check(tag, 64'(obs_q[idx]), 64'(want));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_res = '0;
    m_fl  = 4'b0000;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_ctrl = '0; set_flags = 1'b0; cond = '0;
    m_res = '0; m_fl = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_executed", 64'(executed), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Basic SUB and two-cycle latency
    issue(255, 25, OP_SUB, 1'b1, C_AL);
    check("lat_not_early", 64'(out_valid), 64'd0);
    tick(acc_dummy);
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_result", 64'(result), 64'd230);
    check("basic_executed", 64'(executed), 64'd1);
    check("basic_flags", 64'(flags), 64'b0010);
    drain();

    // Signed boundary, then GE (skip) and HS (execute)
    obs_q.delete();
    issue(32'h8000_0000, 32'h7fff_ffff, OP_SUB, 1'b1, C_AL);
    issue(1, 1, OP_ADD, 1'b0, C_GE);
    issue(2, 2, OP_ADD, 1'b0, C_HS);
    drain();
    check("sgn_count", 64'(obs_q.size()), 64'd3);
    check_obs(0, "sgn_sub", 1, 1'b1, 4'b0011);
    check_obs(1, "sgn_ge_skip", 1, 1'b0, 4'b0011);
    check_obs(2, "sgn_hs_exec", 4, 1'b1, 4'b0011);

    // Back-to-back predication on the previous op's flags
    obs_q.delete();
    issue(0, 0, OP_SUB, 1'b1, C_AL);
    issue(3, 4, OP_ADD, 1'b0, C_EQ);
    issue(1, 1, OP_ADD, 1'b0, C_NE);
    drain();
    check("b2b_count", 64'(obs_q.size()), 64'd3);
    check_obs(0, "b2b_sub00", 0, 1'b1, 4'b0110);
    check_obs(1, "b2b_eq_exec", 7, 1'b1, 4'b0110);
    check_obs(2, "b2b_ne_skip", 7, 1'b0, 4'b0110);

    // Flag generation for logical ops and add overflow/carry
    obs_q.delete();
    issue(32'h8000_0000, 1, OP_OR, 1'b1, C_AL);
    issue(32'hf0, 32'h0f, OP_AND, 1'b1, C_AL);
    issue(32'h7fff_ffff, 1, OP_ADD, 1'b1, C_AL);
    issue(32'hffff_ffff, 1, OP_ADD, 1'b1, C_AL);
    drain();
    check_obs(0, "flg_or", 32'h8000_0001, 1'b1, 4'b1000);
    check_obs(1, "flg_and_zero", 0, 1'b1, 4'b0100);
    check_obs(2, "flg_add_ovf", 32'h8000_0000, 1'b1, 4'b1001);
    check_obs(3, "flg_add_wrap", 0, 1'b1, 4'b0110);

    // Every condition code under three flag settings (0011, 0110, 1000)
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: issue(32'h8000_0000, 32'h7fff_ffff, OP_SUB, 1'b1, C_AL);
        1: issue(0, 0, OP_SUB, 1'b1, C_AL);
        default: issue(1, 2, OP_SUB, 1'b1, C_AL);
      endcase
      for (int c = 0; c < 16; c++) issue(W'(c), 32'h100, OP_ADD, 1'b0, 4'(c));
      drain();
    end

    // Backpressure: stall 3 cycles after the first output
    obs_q.delete();
    saw_block = 0;
    stall_arm = 1;
    for (int i = 1; i <= 4; i++) issue(W'(i), W'(i), OP_ADD, 1'b0, C_AL);
    drain();
    check("bp_count", 64'(obs_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("bp_order", 64'(obs_q[i].res), 64'(2 * (i + 1)));
    check("bp_in_ready_dropped", 64'(saw_block), 64'd1);

    // Random ops with random downstream stalls
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      issue(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    drain();
    rand_ready = 0;

    // Reset while an op is in flight
    issue(5, 9, OP_SUB, 1'b1, C_AL);
    reset = 1'b1;
    #1;
    check("rmid_out_valid", 64'(out_valid), 64'd0);
    check("rmid_flags", 64'(flags), 64'd0);
    check("rmid_result", 64'(result), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_res = '0; m_fl = '0;
    obs_q.delete();
    for (int i = 0; i < 6; i++) tick(acc_dummy);
    check("rmid_no_output", 64'(obs_q.size()), 64'd0);
    check("rmid_flags_after", 64'(flags), 64'd0);
    check("rmid_in_ready", 64'(in_ready), 64'd1);

`ifdef ALU_COND_SKIP_CNT_EN
    do_reset();
    check("skip_rst", 64'(skip_count), 64'd0);
    issue(5, 3, OP_SUB, 1'b1, C_AL);
    drain();
    for (int i = 0; i < 5; i++) begin
      issue(0, 0, OP_ADD, 1'b0, C_LO);
      drain();
      check("skip_count", 64'(skip_count), 64'((i + 1 > 3) ? 3 : i + 1));
    end
`else
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cond_pipe.md
Name: alu_cond_pipe

Overview:
- Parametrised-width, 2-stage pipelined ALU with an architectural NZCV flag register and ARM-style conditional execution.
- Generalises the 32-bit four-function ALU and the flag-driven signed/unsigned comparators: the flags are now stored, and later ops are predicated on them.
- Sits between the decode/issue logic and writeback. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2)
- CNT_WIDTH, 16, width of the skip counter (used only with the optional feature)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  operation accepted when in_valid & in_ready
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_ctrl  input  2  00 ADD, 01 SUB (a-b), 10 AND, 11 OR
- set_flags  input  1  commit NZCV if the op executes
- cond  input  4  execution condition (encoding below)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts when out_valid & out_ready
- result  output  WIDTH  ALU result (held at previous value if skipped)
- executed  output  1  1 = condition passed, 0 = skipped
- flags  output  4  architectural {N,Z,C,V}

Behaviour:
- Reset (async, active-high) clears: stage valids, out_valid=0, result=0, executed=0, flags=4'b0000. in_ready=1 once reset is released.
- Reset mid-operation discards all in-flight ops; no flag commit occurs.
- Stage 1 (cycle after accept): registers the ALU result and the candidate NZCV.
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB: computed as a + ~b + 1. C = no-borrow (a>=b unsigned); V = signed overflow.
  - AND/OR: C=0, V=0.
  - Registers cond, set_flags and ctrl alongside.
- Stage 2 (second cycle after accept):
  - Evaluates cond against the architectural flags.
  - If true: executed=1, result=new value; flags<=candidate if set_flags.
  - If false: executed=0, result unchanged, flags unchanged.
  - out_valid=1.
- Latency: 2 cycles, accept to out_valid. Throughput: 1 op/cycle with no stall.
- Flags are committed in stage 2 at the same edge the next op moves into stage 2. Back-to-back ops therefore see the previous op's flags with no bubble and no forwarding path.
- Condition encoding:
  - 0 EQ Z; 1 NE !Z
  - 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E, F AL
- Backpressure:
  - Stage 2 holds (result, executed, out_valid stable) while out_valid & !out_ready.
  - Stage 1 advances only if stage 2 is empty or draining.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready; no skid buffer).
- Held ops do not evaluate conditions or commit flags until they advance. Each op commits exactly once.
- Simultaneous accept, advance and drain in one cycle is legal; there is no loss or duplication.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry is captured in C.

Optional Feature:
- Macro: ALU_COND_SKIP_CNT_EN.
- Defined:
  - Adds output skip_count [CNT_WIDTH-1:0], reset to 0.
  - Increments once per op that completes stage 2 with executed=0.
  - Saturates at all-ones.
  - Counts on the stage-2 load edge, not per stalled cycle.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic SUB: a=255, b=25, SUB, set_flags, AL -> after 2 cycles result=230, executed=1, flags=0010 (NZCV).
- Signed boundary: WIDTH=32, a=32'h8000_0000, b=32'h7fff_ffff, SUB, set_flags, AL -> result=1, flags=0011.
  - Next op GE -> skipped.
  - Next op HS -> executed.
- Back-to-back predication:
  - Op1: SUB 0-0, set_flags -> flags=0110.
  - Op2: ADD 3+4, cond EQ, issued next cycle -> result=7, executed=1.
  - Op3: ADD 1+1, cond NE -> executed=0, result stays 7.
- Backpressure: stream 4 ADDs (1+1, 2+2, 3+3, 4+4); hold out_ready=0 for 3 cycles after the first out_valid -> outputs 2, 4, 6, 8 in order, none lost or repeated, in_ready drops while full.
- Reset mid-op: accept SUB 5-9 with set_flags; assert reset 1 cycle later -> out_valid=0, flags=0000, no later output appears.
- With ALU_COND_SKIP_CNT_EN, CNT_WIDTH=2: issue 5 ops with cond LO while C=1 -> skip_count = 1, 2, 3, 3, 3.
